// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle controller:
//   - default opcode / branch-LUT index widths
//   - FSM state encoding
//   - opcode class encoding and the numeric opcode values of each class
// The HALT opcode is always the all-ones value of the opcode field, so it is
// not listed as a numeric constant here.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int OPW_DEFAULT  = 4;
  localparam int LUTW_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU_R = 3'd0,
    CLS_ALU_I = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BR    = 3'd4,
    CLS_JMP   = 3'd5,
    CLS_NOP   = 3'd6,
    CLS_HALT  = 3'd7
  } op_class_e;

  localparam int OP_ALU_R = 0;
  localparam int OP_ALU_I = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;
  localparam int OP_BR    = 4;
  localparam int OP_JMP   = 5;
  localparam int OP_NOP   = 6;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode-to-class decoder.
// Ports:
//   opcode   (in,  OPW bits) : raw opcode
//   op_class (out, op_class_e): instruction class; illegal opcodes map to NOP
//   illegal  (out, 1 bit)    : opcode is not one of the defined encodings
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class,
  output logic           illegal
);

  always_comb begin
    op_class = CLS_NOP;
    illegal  = 1'b0;
    // HALT is checked first: with a narrow opcode field the all-ones value
    // must win over any numeric class constant.
    if (opcode == {OPW{1'b1}}) begin
      op_class = CLS_HALT;
    end else if (opcode == OPW'(OP_ALU_R)) begin
      op_class = CLS_ALU_R;
    end else if (opcode == OPW'(OP_ALU_I)) begin
      op_class = CLS_ALU_I;
    end else if (opcode == OPW'(OP_LOAD)) begin
      op_class = CLS_LOAD;
    end else if (opcode == OPW'(OP_STORE)) begin
      op_class = CLS_STORE;
    end else if (opcode == OPW'(OP_BR)) begin
      op_class = CLS_BR;
    end else if (opcode == OPW'(OP_JMP)) begin
      op_class = CLS_JMP;
    end else if (opcode == OPW'(OP_NOP)) begin
      op_class = CLS_NOP;
    end else begin
      // Unknown opcodes execute as NOP and raise the sticky Illegal flag.
      op_class = CLS_NOP;
      illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multicycle processor control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT) with
// latched opcode and branch-LUT index, sticky illegal-opcode flag and a
// saturating retired-instruction counter.
// Ports:
//   Clk, Reset (async, active high), Start
//   Opcode [OPW], LutIdx [LUTW] : sampled in DECODE
//   Zero   : ALU zero flag, conditions BR in EXEC
//   MemAck : data memory completion, only looked at in MEM
//   IRWrite, PCWrite, Branch, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg,
//   RegWrite : datapath strobes
//   Done    : HALT reached
//   Illegal : an illegal opcode was decoded since reset
//   HowHigh [LUTW]    : latched LUT index
//   InstrCount [CNTW] : retired instructions, saturating
// ---------------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW  = OPW_DEFAULT,
  parameter int LUTW = LUTW_DEFAULT,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OPW-1:0]  Opcode,
  input  logic [LUTW-1:0] LutIdx,
  input  logic            Zero,
  input  logic            MemAck,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Branch,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            Done,
  output logic            Illegal,
  output logic [LUTW-1:0] HowHigh,
  output logic [CNTW-1:0] InstrCount
);

  state_e          state_q, state_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [LUTW-1:0] lut_q, lut_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            illegal_q, illegal_d;

  logic [OPW-1:0]  decode_in;
  op_class_e       op_class;
  logic            dec_illegal;

  // In DECODE the live opcode is classified (it decides EXEC vs HALT and the
  // illegal flag); afterwards the latched copy drives the rest of the
  // instruction, so a single decoder serves both.
  assign decode_in = (state_q == ST_DECODE) ? Opcode : opcode_q;

  ctrl_decode #(
    .OPW (OPW)
  ) u_decode (
    .opcode   (decode_in),
    .op_class (op_class),
    .illegal  (dec_illegal)
  );

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      lut_q     <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      lut_q     <= lut_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (op_class == CLS_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (op_class)
          CLS_ALU_R, CLS_ALU_I: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (MemAck) state_d = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: Moore except Branch (Zero in EXEC) and the STORE retire
  // pulse, which has to land in the very cycle MemAck is seen.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Done     = 1'b0;
    case (state_q)
      ST_FETCH: IRWrite = 1'b1;
      ST_EXEC: begin
        RegDst = (op_class == CLS_ALU_R);
        ALUSrc = (op_class == CLS_ALU_I) || (op_class == CLS_LOAD) ||
                 (op_class == CLS_STORE);
        Branch = (op_class == CLS_JMP) || ((op_class == CLS_BR) && Zero);
        // Control-flow, NOP and illegal instructions retire here.
        PCWrite = (op_class == CLS_BR) || (op_class == CLS_JMP) ||
                  (op_class == CLS_NOP);
      end
      ST_MEM: begin
        MemRead  = (op_class == CLS_LOAD);
        MemWrite = (op_class == CLS_STORE);
        PCWrite  = (op_class == CLS_STORE) && MemAck;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (op_class == CLS_LOAD);
        PCWrite  = 1'b1;
      end
      ST_HALT: Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath register updates
  always_comb begin
    opcode_d  = opcode_q;
    lut_d     = lut_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (state_q == ST_DECODE) begin
      opcode_d  = Opcode;
      lut_d     = LutIdx;
      illegal_d = illegal_q | dec_illegal;
    end
    if (PCWrite && (count_q != {CNTW{1'b1}})) begin
      count_d = count_q + CNTW'(1);
    end
  end

  assign Illegal    = illegal_q;
  assign HowHigh    = lut_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Drives instruction sequences into multicycle_control; each instruction
// pushes its expected retire record (latency from FETCH, Branch, HowHigh) to
// a scoreboard queue which a monitor pops on every PCWrite. Per-cycle strobe
// patterns are checked by the driver. A second instance with CNTW=2 shares
// the stimulus so counter saturation is visible.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset, Start, Zero, MemAck;
  logic [3:0]  Opcode;
  logic [2:0]  LutIdx;

  logic        IRWrite, PCWrite, Branch, RegDst, ALUSrc, MemRead, MemWrite;
  logic        MemtoReg, RegWrite, Done, Illegal;
  logic [2:0]  HowHigh;
  logic [15:0] InstrCount;

  logic        d2_IRWrite, d2_PCWrite, d2_Branch, d2_RegDst, d2_ALUSrc;
  logic        d2_MemRead, d2_MemWrite, d2_MemtoReg, d2_RegWrite, d2_Done;
  logic        d2_Illegal;
  logic [2:0]  d2_HowHigh;
  logic [1:0]  d2_InstrCount;

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
    .LutIdx(LutIdx), .Zero(Zero), .MemAck(MemAck),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Done(Done),
    .Illegal(Illegal), .HowHigh(HowHigh), .InstrCount(InstrCount)
  );

  multicycle_control #(.CNTW(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
    .LutIdx(LutIdx), .Zero(Zero), .MemAck(MemAck),
    .IRWrite(d2_IRWrite), .PCWrite(d2_PCWrite), .Branch(d2_Branch),
    .RegDst(d2_RegDst), .ALUSrc(d2_ALUSrc), .MemRead(d2_MemRead),
    .MemWrite(d2_MemWrite), .MemtoReg(d2_MemtoReg), .RegWrite(d2_RegWrite),
    .Done(d2_Done), .Illegal(d2_Illegal), .HowHigh(d2_HowHigh),
    .InstrCount(d2_InstrCount)
  );

  always #5 Clk = ~Clk;

  // Strobe vector {IRWrite,PCWrite,Branch,RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite}
  wire [8:0] vec = {IRWrite, PCWrite, Branch, RegDst, ALUSrc, MemRead,
                    MemWrite, MemtoReg, RegWrite};
  localparam logic [8:0] V_IR = 9'h100, V_PC = 9'h080, V_BR = 9'h040,
                         V_RD = 9'h020, V_AS = 9'h010, V_MR = 9'h008,
                         V_MW = 9'h004, V_M2R = 9'h002, V_RW = 9'h001;

  typedef struct {
    int         lat;
    logic       br;
    logic [2:0] hh;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic exp_ill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // 0..6 = class code, 7 = HALT; illegal opcodes behave as NOP (6)
  function automatic int tb_cls(input int op);
    if (op == 15) return 7;
    if (op <= 6) return op;
    return 6;
  endfunction

  function automatic logic [8:0] exp_vec(input int cls, input int c,
                                         input logic z, input int w);
    logic [8:0] v;
    v = '0;
    if (c == 3) begin
      case (cls)
        0:       v = V_RD;
        1, 2, 3: v = V_AS;
        4:       v = z ? (V_PC | V_BR) : V_PC;
        5:       v = V_PC | V_BR;
        6:       v = V_PC;
        default: v = '0;
      endcase
    end else if (c >= 4) begin
      if (cls == 0 || cls == 1) begin
        if (c == 4) v = V_RW | V_PC;
      end else if (cls == 2) begin
        if (c <= 4 + w) v = V_MR;
        else if (c == 5 + w) v = V_RW | V_M2R | V_PC;
      end else if (cls == 3) begin
        if (c <= 4 + w) v = V_MW | ((c == 4 + w) ? V_PC : 9'h000);
      end
    end
    return v;
  endfunction

  task automatic wait_fetch();
    logic found;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge Clk);
      Start  = 1'b0;
      MemAck = 1'b0;
      #1;
      if (IRWrite) found = 1'b1;
    end
    chk("fetch_irwrite", found, 1'b1);
    chk("fetch_vec", vec, V_IR);
  endtask

  task automatic do_instr(input int op, input logic [2:0] lut,
                          input logic z, input int w);
    int   cls, last;
    exp_t r;
    wait_fetch();
    cls    = tb_cls(op);
    Opcode = op[3:0];
    LutIdx = lut;
    Zero   = z;
    MemAck = 1'b1;  // outside MEM this must have no effect
    if (cls == 7 || cls >= 4) last = 3;
    else if (cls <= 1) last = 4;
    else if (cls == 3) last = 4 + w;
    else last = 5 + w;
    if (cls != 7) begin
      r.lat = last;
      r.br  = (cls == 5) || (cls == 4 && z);
      r.hh  = lut;
      sb_q.push_back(r);
    end
    if (op > 6 && op != 15) exp_ill = 1'b1;
    for (int c = 2; c <= last; c++) begin
      @(negedge Clk);
      MemAck = (c == 2) || ((cls == 2 || cls == 3) && c == 4 + w);
      #1;
      chk("strobes", vec, exp_vec(cls, c, z, w));
      chk("done", Done, (cls == 7 && c == 3));
      if (c >= 3) chk("illegal", Illegal, exp_ill);
    end
    $display("instr op=%0d lut=%0d zero=%0d wait=%0d retire_cycle=%0d",
             op, lut, z, w, last);
  endtask

  // Retire monitor / scoreboard
  int          mcyc = 0;
  logic        pend = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_cnt2 = '0;
  exp_t        mr;

  always begin
    @(negedge Clk);
    #2;
    if (Reset) begin
      mcyc     = 0;
      pend     = 1'b0;
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else begin
      if (pend) begin
        chk("count", InstrCount, exp_cnt);
        chk("count_sat", d2_InstrCount, exp_cnt2);
        pend = 1'b0;
      end
      if (IRWrite) mcyc = 1;
      else mcyc++;
      if (PCWrite) begin
        chk("sb_nonempty", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          mr = sb_q.pop_front();
          chk("latency", mcyc, mr.lat);
          chk("branch", Branch, mr.br);
          chk("howhigh", HowHigh, mr.hh);
        end
        if (exp_cnt != 16'hffff) exp_cnt++;
        if (exp_cnt2 != 2'd3) exp_cnt2++;
        pend = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    sb_q.delete();
    exp_ill = 1'b0;
    #1;
    chk("rst_vec", vec, 9'h000);
    chk("rst_illegal", Illegal, 1'b0);
    chk("rst_count", InstrCount, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Opcode = '0; LutIdx = '0;
    Zero = 1'b0; MemAck = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_vec", vec, 9'h000);
    chk("reset_done", Done, 1'b0);
    chk("reset_count", InstrCount, 16'd0);
    chk("reset_howhigh", HowHigh, 3'd0);
    chk("reset_illegal", Illegal, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      #1;
      chk("idle_hold", vec, 9'h000);
    end

    // Section A: instruction mix ending in HALT
    @(negedge Clk);
    Start = 1'b1;
    do_instr(0, 3'd1, 1'b0, 0);   // ALU_R
    do_instr(2, 3'd2, 1'b0, 3);   // LOAD, ack after 3 wait cycles
    do_instr(4, 3'd5, 1'b1, 0);   // BR taken
    do_instr(4, 3'd5, 1'b0, 0);   // BR not taken
    do_instr(1, 3'd0, 1'b0, 0);   // ALU_I
    do_instr(3, 3'd6, 1'b0, 0);   // STORE, immediate ack
    do_instr(3, 3'd7, 1'b0, 2);   // STORE, 2 wait cycles
    do_instr(5, 3'd3, 1'b0, 0);   // JMP
    do_instr(6, 3'd0, 1'b0, 0);   // NOP
    do_instr(9, 3'd4, 1'b1, 0);   // illegal -> NOP
    do_instr(2, 3'd1, 1'b0, 1);   // LOAD, Illegal must stay set
    do_instr(15, 3'd2, 1'b0, 0);  // HALT
    Start = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      #1;
      chk("halt_done", Done, 1'b1);
      chk("halt_vec", vec, 9'h000);
    end
    Start = 1'b0;
    chk("halt_count", InstrCount, 16'd11);

    // Section B: counter saturation on the CNTW=2 instance
    do_reset();
    @(negedge Clk);
    Start = 1'b1;
    for (int i = 0; i < 5; i++) do_instr(6, 3'(i), 1'b0, 0);
    do_instr(15, 3'd0, 1'b0, 0);
    chk("sat_count2", d2_InstrCount, 2'd3);
    chk("sat_count", InstrCount, 16'd5);

    // Section C: reset in the middle of a STORE's MEM wait
    do_reset();
    @(negedge Clk);
    Start = 1'b1;
    do_instr(6, 3'd0, 1'b0, 0);
    wait_fetch();
    Opcode = 4'd3;
    MemAck = 1'b0;
    for (int c = 2; c <= 4; c++) @(negedge Clk);
    #1;
    chk("mem_memwrite", MemWrite, 1'b1);
    chk("mem_count", InstrCount, 16'd1);
    @(negedge Clk);
    Reset = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_memwrite", MemWrite, 1'b0);
    chk("midrst_vec", vec, 9'h000);
    chk("midrst_count", InstrCount, 16'd0);
    chk("midrst_done", Done, 1'b0);
    $display("instr op=3 reset asserted mid-MEM");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      #1;
      chk("post_rst_idle", vec, 9'h000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
